instruction_fetch: RTL and testbench

Clocked fetch sequencer that sits directly upstream of the control unit.
- On a start pulse it snapshots the flat program image (DEPTH packed WORD_W-bit words, word 0 in the LSBs).
- It then issues the words one at a time, in order, to the control unit over a valid/ready handshake.
- Issue stops at the first all-zero word (halt marker) or after the last slot. The block then reports completion and the number of instructions issued.

---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Valid/ready instruction channel between the fetch sequencer and the
// control unit.
//   addr       : instruction word (driven by master)
//   addr_valid : addr holds a valid instruction (driven by master)
//   addr_ready : control unit accepts addr this cycle (driven by slave)
interface instruction_fetch_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;

    modport master (
        output addr,
        output addr_valid,
        input  addr_ready
    );

    modport slave (
        input  addr,
        input  addr_valid,
        output addr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch sequencer sitting upstream of the control unit. On start it snapshots
// the packed program image, then issues the words in order over a valid/ready
// channel until a zero word (halt marker) or the last slot, and reports
// completion plus the number of instructions accepted.
//
// Ports:
//   clk                : system clock, rising edge
//   reset              : synchronous, active-high
//   start              : run request, honoured only in IDLE
//   program_addr_array : packed image, slot k = bits [(k+1)*WORD_W-1 : k*WORD_W]
//   fetch              : instruction channel (master side: addr/addr_valid out, addr_ready in)
//   pc                 : slot currently fetched/issued
//   busy               : run in progress (FETCH, ISSUE, DONE)
//   done               : one-cycle completion pulse
//   halted_on_zero     : run ended on a zero word
//   issued_count       : instructions accepted in the current/last run
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | read image slot pc; zero ends the run, else present it
// ISSUE  | addr_valid high, waiting for the handshake
// DONE   | one-cycle completion pulse, then back to IDLE
module instruction_fetch #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 10,
    parameter int PC_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WORD_W*DEPTH-1:0]   program_addr_array,
    instruction_fetch_if.master       fetch,
    output logic [PC_W-1:0]           pc,
    output logic                      busy,
    output logic                      done,
    output logic                      halted_on_zero,
    output logic [PC_W-1:0]           issued_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [WORD_W*DEPTH-1:0]   image_q, image_d;
    logic [WORD_W-1:0]         addr_q, addr_d;
    logic                      addr_valid_q, addr_valid_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [PC_W-1:0]           issued_q, issued_d;
    logic                      halted_q, halted_d;
    logic [WORD_W-1:0]         cur_word;

    assign cur_word = image_q[int'(pc_q)*WORD_W +: WORD_W];

    // State and datapath register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            image_q      <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            pc_q         <= '0;
            issued_q     <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            image_q      <= image_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            pc_q         <= pc_d;
            issued_q     <= issued_d;
            halted_q     <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        image_d      = image_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        pc_d         = pc_q;
        issued_d     = issued_q;
        halted_d     = halted_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    image_d  = program_addr_array;
                    pc_d     = '0;
                    issued_d = '0;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cur_word == '0) begin
                    halted_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    addr_d       = cur_word;
                    addr_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (addr_valid_q && fetch.addr_ready) begin
                    addr_valid_d = 1'b0;
                    issued_d     = issued_q + PC_W'(1);
                    // Last slot ends the run without advancing pc past DEPTH-1
                    if (pc_q == PC_W'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign fetch.addr       = addr_q;
    assign fetch.addr_valid = addr_valid_q;
    assign pc               = pc_q;
    assign issued_count     = issued_q;
    assign halted_on_zero   = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 10;
    localparam int PC_W   = 4;
    localparam int HALF   = 5;

    typedef logic [WORD_W*DEPTH-1:0] image_t;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              ready = 1'b0;
    image_t            prog  = '0;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   issued_count;
    logic              busy;
    logic              done;
    logic              halted_on_zero;

    instruction_fetch_if #(.WORD_W(WORD_W)) bus ();
    assign bus.addr_ready = ready;

    instruction_fetch #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .PC_W   (PC_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .program_addr_array (prog),
        .fetch              (bus),
        .pc                 (pc),
        .busy               (busy),
        .done               (done),
        .halted_on_zero     (halted_on_zero),
        .issued_count       (issued_count)
    );

    always #HALF clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] got_q[$];
    int                done_cnt = 0;
    longint            last_hs  = 0;
    logic              stall_seen = 1'b0;
    logic [WORD_W-1:0] stall_addr = '0;
    logic [PC_W-1:0]   stall_pc   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Channel monitor: records accepted words, counts done pulses and checks
    // that a stalled word stays put until it is accepted.
    always @(posedge clk) begin
        if (stall_seen && !reset) begin
            check("stall_valid", 64'(bus.addr_valid), 64'(1));
            check("stall_addr", 64'(bus.addr), 64'(stall_addr));
            check("stall_pc", 64'(pc), 64'(stall_pc));
        end
        stall_seen <= !reset && bus.addr_valid && !bus.addr_ready;
        stall_addr <= bus.addr;
        stall_pc   <= pc;
        if (!reset && bus.addr_valid && bus.addr_ready) begin
            got_q.push_back(bus.addr);
            last_hs <= longint'($time);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Reference: words issued are the prefix before the first zero word.
    task automatic model(input image_t img, output int n, output bit halt, output int fpc);
        logic [WORD_W-1:0] w;
        exp_q.delete();
        halt = 1'b0;
        fpc  = DEPTH - 1;
        for (int k = 0; k < DEPTH; k++) begin
            w = img[k*WORD_W +: WORD_W];
            if (w == '0) begin
                halt = 1'b1;
                fpc  = k;
                break;
            end
            exp_q.push_back(w);
        end
        n = exp_q.size();
    endtask

    task automatic run_prog(input string name, input image_t img, input int ready_pct,
                            input logic [WORD_W-1:0] stall_w, input bit disturb);
        int n, fpc, cyc, stall_n, hs_base, done_base;
        bit halt;
        model(img, n, halt, fpc);
        hs_base   = got_q.size();
        done_base = done_cnt;
        @(negedge clk);
        prog  = img;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ":busy_rise"}, 64'(busy), 64'(1));
        cyc     = 1;
        stall_n = 0;
        while (!done && cyc < 400) begin
            if (cyc == 2 && n > 0) check({name, ":first_valid"}, 64'(bus.addr_valid), 64'(1));
            ready = ($urandom_range(99) < ready_pct);
            if (bus.addr_valid && bus.addr == stall_w && stall_n < 5) begin
                ready = 1'b0;
                stall_n++;
            end
            start = disturb && (cyc == 3);
            if (disturb && cyc == 3) prog = ~img;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, ":done_seen"}, 64'(done), 64'(1));
        if (n == 0)
            check({name, ":done_lat"}, 64'(cyc), 64'(2));
        else
            check({name, ":done_lat"}, 64'(longint'($time) - last_hs), halt ? 64'(3*HALF) : 64'(HALF));
        check({name, ":issued"}, 64'(issued_count), 64'(n));
        check({name, ":halted"}, 64'(halted_on_zero), 64'(halt));
        check({name, ":pc"}, 64'(pc), 64'(fpc));
        check({name, ":valid_low"}, 64'(bus.addr_valid), 64'(0));
        check({name, ":beats"}, 64'(got_q.size() - hs_base), 64'(n));
        for (int i = 0; i < n && hs_base + i < got_q.size(); i++)
            check($sformatf("%s:beat%0d", name, i), 64'(got_q[hs_base + i]), 64'(exp_q[i]));
        if (stall_w != '0) check({name, ":stall_cycles"}, 64'(stall_n), 64'(5));
        if (n > 0) check({name, ":addr_hold"}, 64'(bus.addr), 64'(exp_q[n-1]));
        @(negedge clk);
        check({name, ":busy_fall"}, 64'(busy), 64'(0));
        check({name, ":done_pulse"}, 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        check({name, ":done_count"}, 64'(done_cnt - done_base), 64'(1));
        check({name, ":idle"}, 64'(busy), 64'(0));
    endtask

    task automatic check_reset_values(input string name);
        check({name, ":addr"}, 64'(bus.addr), 64'(0));
        check({name, ":valid"}, 64'(bus.addr_valid), 64'(0));
        check({name, ":pc"}, 64'(pc), 64'(0));
        check({name, ":busy"}, 64'(busy), 64'(0));
        check({name, ":done"}, 64'(done), 64'(0));
        check({name, ":halted"}, 64'(halted_on_zero), 64'(0));
        check({name, ":issued"}, 64'(issued_count), 64'(0));
    endtask

    initial begin
        image_t img;
        int     cyc;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        // 0x11,0x22,0x33 then a zero halt marker
        img = '0;
        for (int k = 0; k < DEPTH; k++) img[k*WORD_W +: WORD_W] = 32'(8'h44 + k);
        img[0*WORD_W +: WORD_W] = 32'h11;
        img[1*WORD_W +: WORD_W] = 32'h22;
        img[2*WORD_W +: WORD_W] = 32'h33;
        img[3*WORD_W +: WORD_W] = 32'h0;
        run_prog("halt3", img, 100, '0, 1'b0);

        // Same image with five cycles of backpressure on 0x22
        run_prog("stall", img, 100, 32'h22, 1'b0);

        // Full image, no halt marker
        for (int k = 0; k < DEPTH; k++) img[k*WORD_W +: WORD_W] = 32'(k + 1);
        run_prog("full", img, 100, '0, 1'b0);

        // Zero in slot 0
        img[0*WORD_W +: WORD_W] = 32'h0;
        run_prog("slot0", img, 100, '0, 1'b0);

        // Image overwrite and start pulse mid-run are ignored
        for (int k = 0; k < DEPTH; k++) img[k*WORD_W +: WORD_W] = $urandom | 32'h1;
        run_prog("snap", img, 70, '0, 1'b1);

        // Reset while word in slot 2 is being issued, with start in the same cycle
        img = '0;
        for (int k = 0; k < 5; k++) img[k*WORD_W +: WORD_W] = 32'(8'hA1 + k);
        @(negedge clk);
        prog  = img;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.addr_valid && bus.addr == 32'hA3) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid:reached_slot2", 64'(bus.addr_valid && bus.addr == 32'hA3), 64'(1));
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_reset_values("rst_mid");
        @(negedge clk);
        check("rst_mid:start_dropped", 64'(busy), 64'(0));
        run_prog("rerun", img, 100, '0, 1'b0);

        // Randomised images and backpressure
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < DEPTH; k++)
                img[k*WORD_W +: WORD_W] = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
            run_prog($sformatf("rand%0d", t), img, int'($urandom_range(100, 30)), '0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
